// File: rtl/instr_sequencer.sv
// instr_sequencer: eight-step microsequencer for a small accumulator CPU.
//
// It arms on the first sampled fetch=1. After that it steps 0..7 repeatedly,
// and on each step it registers the datapath strobes decoded from the
// current step, opcode and zero flag.
//
// Ports:
//   clk          - single clock; all state changes on posedge
//   reset        - synchronous, active-high; returns to IDLE
//   fetch        - fetch phase from the clock generator; arms the sequencer
//   opcode[2:0]  - instruction opcode
//   zero         - accumulator-zero flag (sampled at steps 5 and 7 only)
//   inc_pc, load_acc, load_pc, rd, wr, load_ir, datactl_ena
//                - registered datapath strobes
//   halt         - registered halt indication
//   step[2:0]    - current microstep index (debug)
//
// Parameter HALT_STICKY: 1 = halt latches until reset,
//                        0 = one-cycle halt pulse, sequencing continues.
module instr_sequencer #(
    parameter int HALT_STICKY = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       fetch,
    input  logic [2:0] opcode,
    input  logic       zero,
    output logic       inc_pc,
    output logic       load_acc,
    output logic       load_pc,
    output logic       rd,
    output logic       wr,
    output logic       load_ir,
    output logic       datactl_ena,
    output logic       halt,
    output logic [2:0] step
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RUN    = 2'd1;
    localparam logic [1:0] HALTED = 2'd2;

    localparam logic [2:0] OP_HLT  = 3'b000;
    localparam logic [2:0] OP_SKZ  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_ANDD = 3'b011;
    localparam logic [2:0] OP_XORR = 3'b100;
    localparam logic [2:0] OP_LDA  = 3'b101;
    localparam logic [2:0] OP_STO  = 3'b110;
    localparam logic [2:0] OP_JMP  = 3'b111;

    logic [1:0] mode;
    // Strobe vector order: {inc_pc, load_acc, load_pc, rd, wr, load_ir, datactl_ena}
    logic [6:0] strobes;
    logic [6:0] nxt_strobes;
    logic       nxt_halt;
    logic       alu_op;

    assign alu_op = (opcode == OP_ADD) || (opcode == OP_ANDD) ||
                    (opcode == OP_XORR) || (opcode == OP_LDA);

    always_comb begin
        nxt_strobes = '0;
        nxt_halt    = 1'b0;
        case (step)
            3'd0, 3'd1: begin
                nxt_strobes[3] = 1'b1;  // rd
                nxt_strobes[1] = 1'b1;  // load_ir
                nxt_strobes[6] = 1'b1;  // inc_pc
            end
            3'd2: ;
            3'd3: begin
                nxt_strobes[6] = 1'b1;
                nxt_halt       = (opcode == OP_HLT);
            end
            3'd4: begin
                if (opcode == OP_JMP) nxt_strobes[4] = 1'b1;
                if (alu_op)           nxt_strobes[3] = 1'b1;
                if (opcode == OP_STO) nxt_strobes[0] = 1'b1;
            end
            3'd5: begin
                if (alu_op) begin
                    nxt_strobes[3] = 1'b1;
                    nxt_strobes[5] = 1'b1;
                end
                if (opcode == OP_SKZ && zero) nxt_strobes[6] = 1'b1;
                if (opcode == OP_JMP) begin
                    nxt_strobes[6] = 1'b1;
                    nxt_strobes[4] = 1'b1;
                end
                if (opcode == OP_STO) begin
                    nxt_strobes[2] = 1'b1;
                    nxt_strobes[0] = 1'b1;
                end
            end
            3'd6: begin
                if (alu_op) begin
                    nxt_strobes[3] = 1'b1;
                    nxt_strobes[5] = 1'b1;
                end
                if (opcode == OP_STO) nxt_strobes[0] = 1'b1;
            end
            3'd7: begin
                if (opcode == OP_SKZ && zero) nxt_strobes[6] = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode    <= IDLE;
            step    <= '0;
            strobes <= '0;
            halt    <= 1'b0;
        end else begin
            case (mode)
                IDLE: begin
                    strobes <= '0;
                    halt    <= 1'b0;
                    step    <= '0;
                    if (fetch) mode <= RUN;
                end
                RUN: begin
                    // halt is only ever set by the step-3 HLT decode, so a
                    // registered halt here means the previous edge was that one.
                    if (HALT_STICKY != 0 && halt) begin
                        mode    <= HALTED;
                        strobes <= '0;
                    end else begin
                        strobes <= nxt_strobes;
                        halt    <= nxt_halt;
                        step    <= step + 3'd1;
                    end
                end
                HALTED: begin
                    strobes <= '0;
                    halt    <= 1'b1;
                end
                default: begin
                    mode    <= IDLE;
                    step    <= '0;
                    strobes <= '0;
                    halt    <= 1'b0;
                end
            endcase
        end
    end

    assign inc_pc      = strobes[6];
    assign load_acc    = strobes[5];
    assign load_pc     = strobes[4];
    assign rd          = strobes[3];
    assign wr          = strobes[2];
    assign load_ir     = strobes[1];
    assign datactl_ena = strobes[0];

endmodule

// File: tb/tb_instr_sequencer.sv
// Testbench for instr_sequencer: table of directed vectors against a sticky-halt
// instance, plus a hand-written HLT sequence covering both halt variants.
module tb_instr_sequencer;

    logic       clk = 1'b0;
    logic       reset, fetch, zero;
    logic [2:0] opcode;

    logic a_inc, a_lacc, a_lpc, a_rd, a_wr, a_lir, a_dena, a_halt;
    logic b_inc, b_lacc, b_lpc, b_rd, b_wr, b_lir, b_dena, b_halt;
    logic [2:0] a_step, b_step;

    always #5 clk = ~clk;

    instr_sequencer #(.HALT_STICKY(1)) dut_a (
        .clk(clk), .reset(reset), .fetch(fetch), .opcode(opcode), .zero(zero),
        .inc_pc(a_inc), .load_acc(a_lacc), .load_pc(a_lpc), .rd(a_rd), .wr(a_wr),
        .load_ir(a_lir), .datactl_ena(a_dena), .halt(a_halt), .step(a_step)
    );

    instr_sequencer #(.HALT_STICKY(0)) dut_b (
        .clk(clk), .reset(reset), .fetch(fetch), .opcode(opcode), .zero(zero),
        .inc_pc(b_inc), .load_acc(b_lacc), .load_pc(b_lpc), .rd(b_rd), .wr(b_wr),
        .load_ir(b_lir), .datactl_ena(b_dena), .halt(b_halt), .step(b_step)
    );

    // Strobe order: {inc_pc, load_acc, load_pc, rd, wr, load_ir, datactl_ena}
    localparam logic [6:0] N  = 7'b0000000;
    localparam logic [6:0] F  = 7'b1001010;
    localparam logic [6:0] I  = 7'b1000000;
    localparam logic [6:0] R  = 7'b0001000;
    localparam logic [6:0] RA = 7'b0101000;
    localparam logic [6:0] D  = 7'b0000001;
    localparam logic [6:0] WD = 7'b0000101;
    localparam logic [6:0] P  = 7'b0010000;
    localparam logic [6:0] IP = 7'b1010000;

    localparam logic [2:0] HLT = 3'b000, SKZ = 3'b001, ADD = 3'b010, ANDD = 3'b011;
    localparam logic [2:0] XORR = 3'b100, LDA = 3'b101, STO = 3'b110, JMP = 3'b111;

    typedef struct {
        logic       rst;
        logic       fe;
        logic [2:0] op;
        logic       z;
        logic [6:0] st;
        logic       h;
        logic [2:0] sp;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic void v(logic rst, logic fe, logic [2:0] op, logic z,
                              logic [6:0] st, logic h, logic [2:0] sp);
        vec_t t;
        t.rst = rst; t.fe = fe; t.op = op; t.z = z; t.st = st; t.h = h; t.sp = sp;
        vecs.push_back(t);
    endfunction

    task automatic check(input string name, input logic [6:0] act_st, input logic act_h,
                         input logic [2:0] act_sp, input logic [6:0] exp_st,
                         input logic exp_h, input logic [2:0] exp_sp);
        n_vec++;
        if (act_st !== exp_st || act_h !== exp_h || act_sp !== exp_sp ||
            (act_st[3] === 1'b1 && act_st[2] === 1'b1)) begin
            n_bad++;
            $display("FAIL %s: got strobes=%b halt=%b step=%0d, want strobes=%b halt=%b step=%0d",
                     name, act_st, act_h, act_sp, exp_st, exp_h, exp_sp);
        end
    endtask

    task automatic drive_edge(input logic rst, input logic fe, input logic [2:0] op,
                              input logic z);
        reset = rst; fetch = fe; opcode = op; zero = z;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] a_st();
        return {a_inc, a_lacc, a_lpc, a_rd, a_wr, a_lir, a_dena};
    endfunction

    function automatic logic [6:0] b_st();
        return {b_inc, b_lacc, b_lpc, b_rd, b_wr, b_lir, b_dena};
    endfunction

    // Steps 0..3 of any instruction: fetch, fetch, idle, inc_pc.
    function automatic void front(logic [2:0] op);
        v(0, 0, op, 0, F, 0, 1);
        v(0, 1, op, 0, F, 0, 2);   // fetch ignored while running
        v(0, 0, op, 0, N, 0, 3);
        v(0, 0, op, 0, I, 0, 4);
    endfunction

    initial begin
        reset = 1'b1; fetch = 1'b0; opcode = ADD; zero = 1'b0;

        // reset, reset-over-fetch, idle hold, arm
        v(1, 0, ADD, 0, N, 0, 0);
        v(1, 1, ADD, 0, N, 0, 0);
        v(0, 0, ADD, 0, N, 0, 0);
        v(0, 0, ADD, 0, N, 0, 0);
        v(0, 1, ADD, 0, N, 0, 0);
        // ADD
        front(ADD);
        v(0, 0, ADD, 0, R,  0, 5);
        v(0, 0, ADD, 0, RA, 0, 6);
        v(0, 0, ADD, 0, RA, 0, 7);
        v(0, 0, ADD, 0, N,  0, 0);   // wrap 7->0
        // STO
        front(STO);
        v(0, 0, STO, 0, D,  0, 5);
        v(0, 0, STO, 0, WD, 0, 6);
        v(0, 0, STO, 0, D,  0, 7);
        v(0, 0, STO, 0, N,  0, 0);
        // SKZ with zero=1
        front(SKZ);
        v(0, 0, SKZ, 1, N, 0, 5);
        v(0, 0, SKZ, 1, I, 0, 6);
        v(0, 0, SKZ, 1, N, 0, 7);
        v(0, 0, SKZ, 1, I, 0, 0);
        // SKZ with zero=0 at the sampling steps
        front(SKZ);
        v(0, 0, SKZ, 1, N, 0, 5);
        v(0, 0, SKZ, 0, N, 0, 6);
        v(0, 0, SKZ, 1, N, 0, 7);
        v(0, 0, SKZ, 0, N, 0, 0);
        // SKZ zero sampled independently: 0 at step 5, 1 at step 7
        front(SKZ);
        v(0, 0, SKZ, 1, N, 0, 5);
        v(0, 0, SKZ, 0, N, 0, 6);
        v(0, 0, SKZ, 0, N, 0, 7);
        v(0, 0, SKZ, 1, I, 0, 0);
        // JMP
        front(JMP);
        v(0, 0, JMP, 0, P,  0, 5);
        v(0, 0, JMP, 0, IP, 0, 6);
        v(0, 0, JMP, 0, N,  0, 7);
        v(0, 0, JMP, 0, N,  0, 0);
        // opcode switched mid-instruction: JMP fetched, XORR decoded from step 4
        front(JMP);
        v(0, 0, XORR, 0, R,  0, 5);
        v(0, 0, XORR, 0, RA, 0, 6);
        v(0, 0, LDA,  0, RA, 0, 7);
        v(0, 0, LDA,  0, N,  0, 0);
        // STO interrupted by reset at step 5
        front(STO);
        v(0, 0, STO, 0, D, 0, 5);
        v(1, 0, STO, 0, N, 0, 0);
        v(0, 0, STO, 0, N, 0, 0);
        v(0, 0, STO, 0, N, 0, 0);
        v(0, 1, ANDD, 0, N, 0, 0);
        v(0, 0, ANDD, 0, F, 0, 1);

        @(negedge clk);
        foreach (vecs[k]) begin
            drive_edge(vecs[k].rst, vecs[k].fe, vecs[k].op, vecs[k].z);
            check($sformatf("vec%0d", k), a_st(), a_halt, a_step,
                  vecs[k].st, vecs[k].h, vecs[k].sp);
        end

        // HLT: both instances see identical stimulus.
        drive_edge(1, 0, HLT, 0);
        check("hlt_rst_b", b_st(), b_halt, b_step, N, 0, 0);
        drive_edge(0, 1, HLT, 0);
        drive_edge(0, 0, HLT, 0);
        drive_edge(0, 0, HLT, 0);
        drive_edge(0, 0, HLT, 0);
        check("hlt_s2_a", a_st(), a_halt, a_step, N, 0, 3);
        drive_edge(0, 0, HLT, 0);
        check("hlt_s3_a", a_st(), a_halt, a_step, I, 1, 4);
        check("hlt_s3_b", b_st(), b_halt, b_step, I, 1, 4);
        drive_edge(0, 0, HLT, 0);
        check("hlt_enter_a", a_st(), a_halt, a_step, N, 1, 4);
        check("hlt_pulse_b", b_st(), b_halt, b_step, N, 0, 5);
        for (int i = 0; i < 20; i++) begin
            logic [2:0] bs;
            drive_edge(0, logic'(i % 2 == 0), HLT, 1'(i % 3 == 0));
            check($sformatf("hlt_hold_a%0d", i), a_st(), a_halt, a_step, N, 1, 4);
            bs = 3'((6 + i) % 8);
            n_vec++;
            if (b_step !== bs || b_halt !== (bs == 3'd4)) begin
                n_bad++;
                $display("FAIL hlt_run_b%0d: got step=%0d halt=%b, want step=%0d halt=%b",
                         i, b_step, b_halt, bs, (bs == 3'd4));
            end
        end
        drive_edge(1, 1, HLT, 0);
        check("hlt_reset_a", a_st(), a_halt, a_step, N, 0, 0);
        check("hlt_reset_b", b_st(), b_halt, b_step, N, 0, 0);
        drive_edge(0, 0, HLT, 0);
        drive_edge(0, 0, HLT, 0);
        check("hlt_idle_a", a_st(), a_halt, a_step, N, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have parameter HALT_STICKY, default 1: 1 = halt latches until reset; 0 = halt is a one-cycle pulse and sequencing continues.
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on posedge clk.
REQ-003 SHALL have port reset, input, 1, reset that is synchronous and active-high.
REQ-004 SHALL have port fetch, input, 1, fetch phase from the clock generator; its first high sample arms the sequencer.
REQ-005 SHALL have port opcode, input, 3, instruction opcode from the instruction register.
REQ-006 SHALL have port zero, input, 1, accumulator-zero flag from the ALU.
REQ-007 SHALL have ports inc_pc, load_acc, load_pc, rd, wr, load_ir, datactl_ena, each output, 1, registered datapath strobes.
REQ-008 SHALL have port halt, output, 1, registered halt indication.
REQ-009 SHALL have port step, output, 3, current microstep index (debug).

Function
REQ-010 SHALL decode opcodes: HLT=000, SKZ=001, ADD=010, ANDD=011, XORR=100, LDA=101, STO=110, JMP=111; ALU group = ADD, ANDD, XORR, LDA.
REQ-011 SHALL have three modes: IDLE (not armed), RUN (armed, stepping), HALTED (HALT_STICKY=1 only).
REQ-012 IDLE: all strobes 0, step=0; on a posedge sampling fetch=1, SHALL enter RUN with step=0 and all strobes still 0 for that cycle.
REQ-013 RUN: at each posedge, strobes SHALL be loaded from decode(step, opcode, zero) and step SHALL advance by 1, wrapping 7->0; a step-k strobe pattern is visible in the cycle after the edge at which step==k.
REQ-014 Step 0 and step 1: rd=1, load_ir=1, inc_pc=1, all others 0.
REQ-015 Step 2: all strobes 0.
REQ-016 Step 3: inc_pc=1; if opcode=HLT, halt=1 additionally.
REQ-017 Step 4: JMP -> load_pc=1; ALU group -> rd=1; STO -> datactl_ena=1; other opcodes all 0.
REQ-018 Step 5: ALU group -> rd=1, load_acc=1; SKZ with zero=1 -> inc_pc=1; JMP -> inc_pc=1, load_pc=1; STO -> wr=1, datactl_ena=1.
REQ-019 Step 6: ALU group -> rd=1, load_acc=1; STO -> datactl_ena=1; others all 0.
REQ-020 Step 7: SKZ with zero=1 -> inc_pc=1; otherwise all 0.
REQ-021 zero SHALL be sampled only at the step-5 and step-7 edges, independently at each.
REQ-022 HALT_STICKY=1: after the step-3 edge with HLT, the next edge SHALL enter HALTED: halt=1, all other strobes 0, step frozen at 4; fetch SHALL be ignored; only reset exits.
REQ-023 HALT_STICKY=0: halt SHALL be high for the single step-3 cycle and sequencing SHALL continue normally.
REQ-024 fetch SHALL be ignored in RUN; opcode changes mid-instruction take effect at the next decoded step.
REQ-025 wr and rd SHALL never be high in the same cycle; load_pc SHALL only be high for JMP.

Reset
REQ-026 reset=1 sampled at posedge SHALL force IDLE, step=0, all strobes and halt to 0, from any mode, including mid-instruction and HALTED.
REQ-027 reset SHALL take priority over fetch at the same edge; the sequencer stays IDLE.
REQ-028 After reset deasserts, the sequencer SHALL remain IDLE until fetch=1 is sampled.

Verification
REQ-029 Reset, then fetch=1 for 1 cycle, opcode=ADD -> strobes 0 on arming cycle; rd/load_ir/inc_pc=1 in two cycles; load_acc=1 in steps 5,6; step wraps 7->0.
REQ-030 opcode=STO -> datactl_ena=1 in steps 4-6, wr=1 only in step 5, rd=0 in steps 4-7.
REQ-031 opcode=SKZ: zero=1 -> inc_pc=1 in steps 5 and 7; zero=0 -> inc_pc=0 in steps 4-7.
REQ-032 opcode=JMP -> load_pc=1 in steps 4,5; inc_pc=1 in step 5.
REQ-033 opcode=HLT, HALT_STICKY=1 -> halt=1 from step 3 onward, step=4 held for 20 cycles with fetch toggling; reset -> halt=0, IDLE; HALT_STICKY=0 -> halt pulse of 1 cycle, step continues 4..7.
REQ-034 Reset asserted at step 5 of STO -> next cycle all strobes 0, step=0; no wr pulse after reset.
